// File: rtl/key_event_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_event_pkg : event field layout and lowest-set-bit helper     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package key_event_pkg;

  localparam int EV_W          = 6;
  localparam int EV_REPEAT_BIT = 5;
  localparam int EV_PRESS_BIT  = 4;
  localparam int EV_KEY_LSB    = 0;
  localparam int EV_KEY_W      = 4;
  localparam int N_KEYS        = 16;

  typedef struct packed {
    logic                rpt;
    logic                press;
    logic [EV_KEY_W-1:0] key;
  } key_event_t;

  function automatic logic [EV_KEY_W-1:0] lowest_set_idx(input logic [N_KEYS-1:0] vec);
    logic [EV_KEY_W-1:0] idx;
    idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (vec[i]) idx = EV_KEY_W'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_event_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_event_queue_if : valid/ready event stream to the consumer    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface key_event_queue_if;
  import key_event_pkg::*;

  logic [EV_W-1:0] ev_data;
  logic            ev_valid;
  logic            ev_ready;

  modport master (output ev_data, output ev_valid, input ev_ready);
  modport slave  (input ev_data, input ev_valid, output ev_ready);

endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | sync_fifo : show-ahead FIFO, power-of-two depth, full/empty/count|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire                         push_i,
  input  wire  [WIDTH-1:0]            data_i,
  input  wire                         pop_i,
  output logic [WIDTH-1:0]            data_o,
  output logic                        full_o,
  output logic                        empty_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               push_en, pop_en;

  assign full_o  = (count_q == c_cnt_w'(DEPTH));
  assign empty_o = (count_q == '0);
  // A pop never frees room for a same-cycle push when full.
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    if (pop_en)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    if (push_en && !pop_en)      count_d = count_q + c_cnt_w'(1);
    else if (!push_en && pop_en) count_d = count_q - c_cnt_w'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/key_event_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | key_event_queue : key level vector -> press/release/repeat queue |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module key_event_queue
  import key_event_pkg::*;
#(
  parameter int DEPTH         = 8,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000
) (
  input  wire                         clk,
  input  wire                         rst,
  input  wire  [N_KEYS-1:0]           btn_i,
  key_event_queue_if.master           ev_if,
  output logic [$clog2(DEPTH+1)-1:0]  ev_count_o,
  output logic                        busy_o
);

  logic [N_KEYS-1:0]   btn_r_q;
  logic [N_KEYS-1:0]   reported_q, reported_d;
  logic [N_KEYS-1:0]   diff;
  logic                diff_zero;
  logic [EV_KEY_W-1:0] chg_key;
  logic                chg_press;
  logic                chg_push;
  logic                rep_due;
  logic [EV_KEY_W-1:0] rep_key;
  logic                fifo_full, fifo_empty, fifo_push;
  logic [EV_W-1:0]     fifo_dout;
  key_event_t          push_ev;

  assign diff      = btn_r_q ^ reported_q;
  assign diff_zero = (diff == '0);
  assign chg_key   = lowest_set_idx(diff);
  assign chg_press = btn_r_q[chg_key];
  assign chg_push  = ~diff_zero & ~fifo_full;
  assign busy_o    = ~diff_zero;

  always_comb begin
    reported_d = reported_q;
    if (chg_push) reported_d[chg_key] = chg_press;
  end

  // Change events win the single push slot; a repeat only uses an idle one.
  always_comb begin
    push_ev   = '0;
    fifo_push = 1'b0;
    if (chg_push) begin
      push_ev.press = chg_press;
      push_ev.key   = chg_key;
      fifo_push     = 1'b1;
    end else if (rep_due && !fifo_full) begin
      push_ev.rpt   = 1'b1;
      push_ev.press = 1'b1;
      push_ev.key   = rep_key;
      fifo_push     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_r_q    <= '0;
      reported_q <= '0;
    end else begin
      btn_r_q    <= btn_i;
      reported_q <= reported_d;
    end
  end

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_rep_w   = (c_rep_max > 1) ? $clog2(c_rep_max) : 1;

    logic [c_rep_w-1:0]  rep_cnt_q, rep_cnt_d;
    logic [EV_KEY_W-1:0] last_key_q, last_key_d;
    logic                rep_active_q, rep_active_d;
    logic                held;

    assign held    = rep_active_q & btn_r_q[last_key_q];
    assign rep_due = held & (rep_cnt_q == '0) & diff_zero;
    assign rep_key = last_key_q;

    // At zero the counter holds until diff clears; fire or skip both reload the period.
    always_comb begin
      rep_cnt_d    = rep_cnt_q;
      last_key_d   = last_key_q;
      rep_active_d = rep_active_q;
      if (chg_push && chg_press) begin
        last_key_d   = chg_key;
        rep_active_d = 1'b1;
        rep_cnt_d    = c_rep_w'(REPEAT_DELAY - 1);
      end else if (chg_push && (chg_key == last_key_q)) begin
        rep_active_d = 1'b0;
      end else if (held) begin
        if (rep_cnt_q != '0)  rep_cnt_d = rep_cnt_q - c_rep_w'(1);
        else if (diff_zero)   rep_cnt_d = c_rep_w'(REPEAT_PERIOD - 1);
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rep_cnt_q    <= '0;
        last_key_q   <= '0;
        rep_active_q <= 1'b0;
      end else begin
        rep_cnt_q    <= rep_cnt_d;
        last_key_q   <= last_key_d;
        rep_active_q <= rep_active_d;
      end
    end
  end else begin : g_no_repeat
    assign rep_due = 1'b0;
    assign rep_key = '0;
  end

  sync_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (push_ev),
    .pop_i   (ev_if.ev_ready & ~fifo_empty),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (ev_count_o)
  );

  assign ev_if.ev_data  = fifo_dout;
  assign ev_if.ev_valid = ~fifo_empty;

endmodule
`default_nettype wire

// File: doc/key_event_queue.md
# key_event_queue

Converts the debounced 16-bit key level vector from the matrix keypad scanner into a serialized stream of discrete key events. Events are press, release and auto-repeat, and each carries the key index. Events are buffered in a small FIFO and handed to the consumer (display/control logic) over a valid/ready handshake. The block sits directly downstream of the keypad scanner, in the same clock domain as its consumer.

## Interface
- `DEPTH`, default 8: FIFO entries; must be a power of two, ≥2.
- `REPEAT_EN`, default 1: enables auto-repeat events.
- `REPEAT_DELAY`, default 25_000_000: cycles a key must be held before the first repeat event.
- `REPEAT_PERIOD`, default 5_000_000: cycles between subsequent repeat events.
- `clk`, in, 1: the only clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `btn`, in, 16: debounced key levels, 1 = pressed.
  - Index = row*4 + col, matching keypad numbering 00..15.
  - Already stable from the scanner; no synchronizer is required when the scanner shares `clk`.
- `ev_data`, out, 6: `[5]` repeat flag, `[4]` press(1)/release(0), `[3:0]` key index.
- `ev_valid`, out, 1: FIFO non-empty; `ev_data` is valid.
- `ev_ready`, in, 1: consumer accepts the head entry.
- `ev_count`, out, $clog2(DEPTH+1): current FIFO occupancy.
- `busy`, out, 1: unreported level changes are pending.

## Operation
- `btn_r` register: copy of `btn` every cycle.
- `reported` register: last level emitted per key.
- Change detection: `diff = btn_r ^ reported`.
- Change events:
  - Each cycle with `diff != 0` and FIFO not full, select the lowest set index `k` in `diff`.
  - Push `{0, btn_r[k], k}`, then set `reported[k] <= btn_r[k]`.
  - Exactly one event per cycle; multiple simultaneous changes drain lowest index first.
- FIFO full: no push; `diff` persists, so no event is ever lost.
  - A key that toggles twice while stalled produces no event; net-zero change is intended.
- Repeat tracking: `last_key` (4 bits) and `rep_active` record the most recent emitted press.
  - `rep_cnt` loads `REPEAT_DELAY-1` when that press is pushed.
  - `rep_cnt` decrements each cycle while `btn_r[last_key]=1` and `rep_active`.
  - A release of `last_key` being pushed clears `rep_active`.
  - A press of another key retargets `last_key` and reloads `REPEAT_DELAY-1`.
- Repeat emission:
  - Due when `rep_cnt==0`. Push `{1, 1, last_key}` and reload `REPEAT_PERIOD-1`.
  - Change events have priority: while `diff != 0`, the counter holds at 0 and the repeat fires on the first cycle with `diff == 0`.
  - If the FIFO is full when due, skip the repeat and reload `REPEAT_PERIOD-1`; repeats are droppable, change events are not.
  - With `REPEAT_EN=0`, repeat logic is absent and no repeat events occur.
- FIFO: show-ahead, with `ev_data` = head.
  - Pop when `ev_valid & ev_ready`.
  - Push and pop in the same cycle are both honored when not full; count is unchanged.
  - When full, a push is blocked even if a pop occurs in the same cycle.
  - Pointers are `log2(DEPTH)` bits and wrap naturally.
- `busy = (diff != 0)`.

## Timing
- Reset values:
  - `ev_valid=0`, `ev_count=0`, `busy=0`, `ev_data=0`.
  - `btn_r=0`, `reported=0`, `rep_active=0`, `rep_cnt=0`, FIFO pointers 0.
- Reset mid-operation: FIFO contents are discarded and all pending changes are cleared.
  - A key still held after reset produces a fresh press event. `btn_r` fills 1 cycle after reset deasserts, so the event appears 2 cycles later.
- Latency, empty FIFO and no backlog:
  - `btn` change sampled at edge N, then `btn_r` updates at N, push at N+1, `ev_valid`/`ev_data` visible after N+1.
  - Total 2 cycles from `btn` change to `ev_valid`.
- Throughput: 1 event per cycle in, 1 event per cycle out.
- The first repeat occurs `REPEAT_DELAY` cycles after the press push. Later repeats occur every `REPEAT_PERIOD` cycles, absent stalls.

## Structure
- Package `key_event_pkg`:
  - Event field positions (`EV_REPEAT_BIT=5`, `EV_PRESS_BIT=4`, `EV_KEY_LSB=0`, `EV_KEY_W=4`), `EV_W=6`, `N_KEYS=16`.
  - A function for lowest-set-bit index of a 16-bit vector.
- One sub-module, `sync_fifo`, parameterized by width and depth, exposing full/empty/count.
  - Change detection, repeat counter and push arbitration live in the top.

## Test plan
- Setup: `DEPTH=4`, `REPEAT_DELAY=20`, `REPEAT_PERIOD=5`.
- Single press/release: `btn=16'h0020` then back to 0, with `ev_ready=1`.
  - Expect `6'h15` then `6'h05`; `ev_valid` rises 2 cycles after each edge.
- Simultaneous: `btn` goes 0→`16'h8101`, with `ev_ready=1`.
  - Expect events `6'h10`, `6'h18`, `6'h1F` on consecutive cycles; `busy` is high for 3 cycles.
- Backpressure: `ev_ready=0`, toggle 6 distinct keys on.
  - `ev_count` saturates at 4 and `busy` stays 1.
  - Raise `ev_ready`: all 6 press events arrive in index order, none lost.
- Repeat: hold key 3 for 40 cycles, with `ev_ready=1`.
  - Expect `6'h13`, then `6'h33` at +20, +25, +30, +35 cycles.
  - Release gives `6'h03` and no further repeats.
- Repeat drop and reset: hold key 3 with `ev_ready=0` until the FIFO is full.
  - Repeats are skipped and `ev_count` stays 4.
  - Assert `rst` for 1 cycle: `ev_count=0`, `ev_valid=0`; 2 cycles later `6'h13` reappears.
